// File: rtl/ysyx_22041211_alu_arb_if.sv
// Request/response bundle between the two ALU requesters (EXU, LSU) and the
// shared ALU arbiter.
interface ysyx_22041211_alu_arb_if #(
  parameter int DATA_LEN = 32
);
  logic                req0_valid;
  logic                req0_ready;
  logic [DATA_LEN-1:0] req0_src1;
  logic [DATA_LEN-1:0] req0_src2;
  logic [3:0]          req0_op;
  logic                req1_valid;
  logic                req1_ready;
  logic [DATA_LEN-1:0] req1_src1;
  logic [DATA_LEN-1:0] req1_src2;
  logic [3:0]          req1_op;
  logic                resp0_valid;
  logic                resp0_ready;
  logic [DATA_LEN-1:0] resp0_result;
  logic                resp1_valid;
  logic                resp1_ready;
  logic [DATA_LEN-1:0] resp1_result;

  modport master (
    output req0_valid, req0_src1, req0_src2, req0_op,
    output req1_valid, req1_src1, req1_src2, req1_op,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_result, resp1_valid, resp1_result
  );

  modport slave (
    input  req0_valid, req0_src1, req0_src2, req0_op,
    input  req1_valid, req1_src1, req1_src2, req1_op,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_result, resp1_valid, resp1_result
  );
endinterface

// File: rtl/ysyx_22041211_alu_arb.sv
// Round-robin arbiter sharing one combinational ALU between EXU (port 0) and
// LSU (port 1); a single result register is returned to the winning port.
module ysyx_22041211_alu_arb #(
  parameter int DATA_LEN = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_22041211_alu_arb_if.slave    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state;
  logic                own;
  logic                last;
  logic [DATA_LEN-1:0] result;

  logic                handshake;
  logic                can_accept;
  logic                any_req;
  logic                grant;
  logic                accept;
  logic [DATA_LEN-1:0] src1;
  logic [DATA_LEN-1:0] src2;
  logic [3:0]          op;
  logic [4:0]          shamt;
  logic [DATA_LEN-1:0] alu_out;

  // A draining response frees the register in the same cycle, so a new
  // operation can land with no bubble.
  always_comb begin
    handshake  = (state == HOLD) & (own ? bus.resp1_ready : bus.resp0_ready);
    can_accept = (state == IDLE) | handshake;
    any_req    = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid & bus.req1_valid) begin
      grant = ~last;
    end else begin
      grant = bus.req1_valid;
    end
    accept = can_accept & any_req;
  end

  always_comb begin
    src1  = grant ? bus.req1_src1 : bus.req0_src1;
    src2  = grant ? bus.req1_src2 : bus.req0_src2;
    op    = grant ? bus.req1_op   : bus.req0_op;
    shamt = src2[4:0];
    alu_out = '0;
    case (op)
      4'b0000: alu_out = src1 + src2;
      4'b0001: alu_out = src1 - src2;
      4'b0010: alu_out = src1 << shamt;
      4'b0011: alu_out = {{(DATA_LEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      4'b0100: alu_out = {{(DATA_LEN-1){1'b0}}, (src1 < src2)};
      4'b0101: alu_out = src1 ^ src2;
      4'b0110: alu_out = src1 >> shamt;
      4'b0111: alu_out = $unsigned($signed(src1) >>> shamt);
      4'b1000: alu_out = src1 | src2;
      4'b1001: alu_out = src1 & src2;
      default: alu_out = '0;
    endcase
  end

  // last starts at 1 so port 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      own    <= 1'b0;
      last   <= 1'b1;
      result <= '0;
    end else if (accept) begin
      state  <= HOLD;
      own    <= grant;
      last   <= grant;
      result <= alu_out;
    end else if (handshake) begin
      state  <= IDLE;
    end
  end

  assign bus.req0_ready   = can_accept & bus.req0_valid & ~grant;
  assign bus.req1_ready   = can_accept & bus.req1_valid & grant;
  assign bus.resp0_valid  = (state == HOLD) & ~own;
  assign bus.resp1_valid  = (state == HOLD) & own;
  assign bus.resp0_result = result;
  assign bus.resp1_result = result;

endmodule

// File: tb/tb_ysyx_22041211_alu_arb.sv
// Directed and scoreboarded random tests for the shared-ALU arbiter.
module tb_ysyx_22041211_alu_arb;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  ysyx_22041211_alu_arb_if #(.DATA_LEN(32)) bus ();

  ysyx_22041211_alu_arb #(.DATA_LEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference for the ALU encoding.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ext;
    logic [4:0]  sh;
    sh = b[4:0];
    case (op)
      4'd0: alu_ref = a + b;
      4'd1: alu_ref = a + ~b + 32'd1;
      4'd2: alu_ref = a << sh;
      4'd3: alu_ref = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'd4: alu_ref = {31'd0, a < b};
      4'd5: alu_ref = a ^ b;
      4'd6: alu_ref = a >> sh;
      4'd7: begin
        ext = {{32{a[31]}}, a} >> sh;
        alu_ref = ext[31:0];
      end
      4'd8: alu_ref = a | b;
      4'd9: alu_ref = a & b;
      default: alu_ref = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0: rand_operand = $urandom;
      1: rand_operand = 32'h8000_0000;
      2: rand_operand = 32'hFFFF_FFFF;
      default: rand_operand = $urandom_range(0, 40);
    endcase
  endfunction

  task automatic set_idle();
    bus.req0_valid = 1'b0; bus.req0_src1 = '0; bus.req0_src2 = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_src1 = '0; bus.req1_src2 = '0; bus.req1_op = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.resp0_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp0_valid got %b want 0", bus.resp0_valid); end
    vectors++; if (bus.resp1_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp1_valid got %b want 0", bus.resp1_valid); end
    vectors++; if (bus.req0_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req0_ready got %b want 0", bus.req0_ready); end
    vectors++; if (bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req1_ready got %b want 0", bus.req1_ready); end
    vectors++; if (bus.resp0_result !== 32'd0) begin miscompares++; $display("FAIL reset_result got %h want 0", bus.resp0_result); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    @(posedge clk); #1;
    bus.resp0_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_src1 = 32'd5; bus.req0_src2 = 32'd7;
    #1;
    vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL add_req0_ready got %b want 1", bus.req0_ready); end
    vectors++; if (bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL add_req1_ready got %b want 0", bus.req1_ready); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    vectors++; if (bus.resp0_valid !== 1'b1) begin miscompares++; $display("FAIL add_resp0_valid got %b want 1", bus.resp0_valid); end
    vectors++; if (bus.resp0_result !== 32'd12) begin miscompares++; $display("FAIL add_result got %h want 0000000c", bus.resp0_result); end
    vectors++; if (bus.resp1_valid !== 1'b0) begin miscompares++; $display("FAIL add_resp1_valid got %b want 0", bus.resp1_valid); end
  endtask

  task automatic test_ops();
    logic [3:0]  ops [14];
    logic [31:0] av  [14];
    logic [31:0] bv  [14];
    logic [31:0] ev  [14];
    ops[0]  = 4'h1; av[0]  = 32'd3;         bv[0]  = 32'd5;         ev[0]  = 32'hFFFF_FFFE;
    ops[1]  = 4'h3; av[1]  = 32'hFFFF_FFFF; bv[1]  = 32'd1;         ev[1]  = 32'd1;
    ops[2]  = 4'h4; av[2]  = 32'hFFFF_FFFF; bv[2]  = 32'd1;         ev[2]  = 32'd0;
    ops[3]  = 4'h7; av[3]  = 32'h8000_0000; bv[3]  = 32'd4;         ev[3]  = 32'hF800_0000;
    ops[4]  = 4'hF; av[4]  = 32'h1234_5678; bv[4]  = 32'd9;         ev[4]  = 32'd0;
    ops[5]  = 4'h0; av[5]  = 32'hFFFF_FFFF; bv[5]  = 32'd1;         ev[5]  = 32'd0;
    ops[6]  = 4'h2; av[6]  = 32'd1;         bv[6]  = 32'd33;        ev[6]  = 32'd2;
    ops[7]  = 4'h6; av[7]  = 32'h8000_0000; bv[7]  = 32'd31;        ev[7]  = 32'd1;
    ops[8]  = 4'h5; av[8]  = 32'hF0F0_F0F0; bv[8]  = 32'hFF00_FF00; ev[8]  = 32'h0FF0_0FF0;
    ops[9]  = 4'h8; av[9]  = 32'hF0F0_F0F0; bv[9]  = 32'h0F0F_0000; ev[9]  = 32'hFFFF_F0F0;
    ops[10] = 4'h9; av[10] = 32'hF0F0_F0F0; bv[10] = 32'hFF00_FF00; ev[10] = 32'hF000_F000;
    ops[11] = 4'hA; av[11] = 32'd1;         bv[11] = 32'd1;         ev[11] = 32'd0;
    ops[12] = 4'h3; av[12] = 32'd1;         bv[12] = 32'hFFFF_FFFF; ev[12] = 32'd0;
    ops[13] = 4'h4; av[13] = 32'd1;         bv[13] = 32'hFFFF_FFFF; ev[13] = 32'd1;
    @(posedge clk); #1;
    bus.resp1_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      bus.req1_valid = 1'b1; bus.req1_op = ops[i]; bus.req1_src1 = av[i]; bus.req1_src2 = bv[i];
      #1;
      vectors++; if (bus.req1_ready !== 1'b1) begin miscompares++; $display("FAIL ops_req1_ready[%0d] got %b want 1", i, bus.req1_ready); end
      @(posedge clk); #1;
      vectors++; if (bus.resp1_valid !== 1'b1) begin miscompares++; $display("FAIL ops_resp1_valid[%0d] got %b want 1", i, bus.resp1_valid); end
      vectors++; if (bus.resp1_result !== ev[i]) begin miscompares++; $display("FAIL ops_result[%0d] op %h got %h want %h", i, ops[i], bus.resp1_result, ev[i]); end
    end
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int k0;
    int k1;
    int expg;
    logic [31:0] exp_res;
    k0 = 0; k1 = 0; expg = 0;
    @(posedge clk); #1;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_src1 = 32'(k0 * 3 + 1); bus.req0_src2 = 32'd100;
      bus.req1_valid = 1'b1; bus.req1_op = 4'd1; bus.req1_src1 = 32'd1000;       bus.req1_src2 = 32'(k1 + 7);
      #1;
      vectors++; if (bus.req0_ready !== (expg == 0)) begin miscompares++; $display("FAIL b2b_req0_ready[%0d] got %b want %b", i, bus.req0_ready, expg == 0); end
      vectors++; if (bus.req1_ready !== (expg == 1)) begin miscompares++; $display("FAIL b2b_req1_ready[%0d] got %b want %b", i, bus.req1_ready, expg == 1); end
      @(posedge clk); #1;
      if (expg == 0) begin
        exp_res = 32'(k0 * 3 + 1 + 100);
        k0++;
      end else begin
        exp_res = 32'(1000 - (k1 + 7));
        k1++;
      end
      vectors++; if (bus.resp0_valid !== (expg == 0) || bus.resp1_valid !== (expg == 1)) begin
        miscompares++; $display("FAIL b2b_tag[%0d] got v0=%b v1=%b want port %0d", i, bus.resp0_valid, bus.resp1_valid, expg);
      end
      vectors++; if (bus.resp0_result !== exp_res) begin miscompares++; $display("FAIL b2b_result[%0d] got %h want %h", i, bus.resp0_result, exp_res); end
      expg = 1 - expg;
    end
    set_idle();
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_src1 = 32'd10; bus.req0_src2 = 32'd20;
    #1;
    vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL bp_accept got %b want 1", bus.req0_ready); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 4'd5; bus.req1_src1 = 32'd7; bus.req1_src2 = 32'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (bus.resp0_valid !== 1'b1) begin miscompares++; $display("FAIL bp_resp0_valid[%0d] got %b want 1", i, bus.resp0_valid); end
      vectors++; if (bus.resp0_result !== 32'd30) begin miscompares++; $display("FAIL bp_result[%0d] got %h want 0000001e", i, bus.resp0_result); end
      vectors++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_ready[%0d] got r0=%b r1=%b want 0 0", i, bus.req0_ready, bus.req1_ready);
      end
      vectors++; if (bus.resp1_valid !== 1'b0) begin miscompares++; $display("FAIL bp_resp1_valid[%0d] got %b want 0", i, bus.resp1_valid); end
      @(posedge clk); #1;
    end
    bus.resp0_ready = 1'b1;
    #1;
    vectors++; if (bus.req1_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_req1_ready got %b want 1", bus.req1_ready); end
    @(posedge clk); #1;
    vectors++; if (bus.resp1_valid !== 1'b1 || bus.resp0_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_release_tag got v0=%b v1=%b want 0 1", bus.resp0_valid, bus.resp1_valid);
    end
    vectors++; if (bus.resp1_result !== 32'd4) begin miscompares++; $display("FAIL bp_release_result got %h want 00000004", bus.resp1_result); end
    set_idle();
  endtask

  task automatic test_reset_mid_hold();
    @(posedge clk); #1;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 4'd0; bus.req1_src1 = 32'd2; bus.req1_src2 = 32'd3;
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    vectors++; if (bus.resp1_valid !== 1'b1 || bus.resp1_result !== 32'd5) begin
      miscompares++; $display("FAIL rst_hold_pre got v1=%b res=%h want 1 00000005", bus.resp1_valid, bus.resp1_result);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (bus.resp1_valid !== 1'b0) begin miscompares++; $display("FAIL rst_hold_async_valid got %b want 0", bus.resp1_valid); end
    vectors++; if (bus.resp1_result !== 32'd0) begin miscompares++; $display("FAIL rst_hold_result got %h want 0", bus.resp1_result); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.resp1_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_src1 = 32'd1; bus.req0_src2 = 32'd1;
    bus.req1_valid = 1'b1; bus.req1_op = 4'd0; bus.req1_src1 = 32'd2; bus.req1_src2 = 32'd2;
    #1;
    vectors++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      miscompares++; $display("FAIL rst_tie got r0=%b r1=%b want 1 0", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    bus.req0_src1 = 32'd8;
    vectors++; if (bus.resp0_valid !== 1'b1 || bus.resp0_result !== 32'd2) begin
      miscompares++; $display("FAIL rst_tie_result got v0=%b res=%h want 1 00000002", bus.resp0_valid, bus.resp0_result);
    end
    #1;
    vectors++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      miscompares++; $display("FAIL starve got r0=%b r1=%b want 0 1", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    vectors++; if (bus.resp1_valid !== 1'b1 || bus.resp1_result !== 32'd4) begin
      miscompares++; $display("FAIL starve_result got v1=%b res=%h want 1 00000004", bus.resp1_valid, bus.resp1_result);
    end
    set_idle();
  endtask

  task automatic test_random();
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] exp_res;
    logic        acc0;
    logic        acc1;
    logic        gen;
    acc0 = 1'b0; acc1 = 1'b0;
    for (int i = 0; i < 406; i++) begin
      gen = (i < 400);
      @(posedge clk); #1;
      if (!bus.req0_valid || acc0) begin
        bus.req0_valid = gen && ($urandom_range(0, 2) != 0);
        bus.req0_op = 4'($urandom_range(0, 15)); bus.req0_src1 = rand_operand(); bus.req0_src2 = rand_operand();
      end
      if (!bus.req1_valid || acc1) begin
        bus.req1_valid = gen && ($urandom_range(0, 2) != 0);
        bus.req1_op = 4'($urandom_range(0, 15)); bus.req1_src1 = rand_operand(); bus.req1_src2 = rand_operand();
      end
      bus.resp0_ready = !gen || ($urandom_range(0, 3) != 0);
      bus.resp1_ready = !gen || ($urandom_range(0, 3) != 0);
      #1;
      if (bus.resp0_valid && bus.resp0_ready) begin
        vectors++;
        if (q0.size() == 0) begin
          miscompares++; $display("FAIL rand_dup0 cycle %0d got unexpected result %h want none", i, bus.resp0_result);
        end else begin
          exp_res = q0.pop_front();
          if (bus.resp0_result !== exp_res) begin miscompares++; $display("FAIL rand_result0 cycle %0d got %h want %h", i, bus.resp0_result, exp_res); end
        end
      end
      if (bus.resp1_valid && bus.resp1_ready) begin
        vectors++;
        if (q1.size() == 0) begin
          miscompares++; $display("FAIL rand_dup1 cycle %0d got unexpected result %h want none", i, bus.resp1_result);
        end else begin
          exp_res = q1.pop_front();
          if (bus.resp1_result !== exp_res) begin miscompares++; $display("FAIL rand_result1 cycle %0d got %h want %h", i, bus.resp1_result, exp_res); end
        end
      end
      vectors++; if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) begin
        miscompares++; $display("FAIL rand_double_grant cycle %0d got both ready want at most one", i);
      end
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      if (acc0) q0.push_back(alu_ref(bus.req0_op, bus.req0_src1, bus.req0_src2));
      if (acc1) q1.push_back(alu_ref(bus.req1_op, bus.req1_src1, bus.req1_src2));
    end
    vectors++; if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++; $display("FAIL rand_lost got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
    set_idle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_alu_arb.md
# ysyx_22041211_alu_arb

Two-port arbiter and sequencer that shares the core's single combinational ALU between two requesters: port 0 is the EXU and port 1 is the LSU address/compare path. It accepts one operation per cycle under round-robin arbitration, evaluates it on the ALU and registers the 32-bit result. It returns the result to the winning port over a valid/ready response channel. Throughput is one operation per cycle when responses are consumed immediately.

## Interface
- DATA_LEN, 32, operand/result width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  operation request per port
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_src1, req0_src2 / req1_src1, req1_src2  in  DATA_LEN  operands per port
- req0_op / req1_op  in  4  ALU operation code per port
- resp0_valid / resp1_valid  out  1  result available for that port
- resp0_ready / resp1_ready  in  1  port consumes result
- resp0_result / resp1_result  out  DATA_LEN  registered result; both ports are driven from the same register

## Operation
- ALU op encoding (codes 1010–1111 yield 0):
  - 0000 add
  - 0001 sub
  - 0010 sll by src2[4:0]
  - 0011 slt (signed, 1/0)
  - 0100 sltu (1/0)
  - 0101 xor
  - 0110 srl
  - 0111 sra (arithmetic)
  - 1000 bitwise or
  - 1001 and
- Result width is DATA_LEN. Carries and overflow are dropped, with wrap-around modulo 2^DATA_LEN.
- FSM has two states:
  - IDLE: output register empty.
  - HOLD: register holds a result for owner port `own`.
- Accept condition: `can_accept = (state==IDLE) | (state==HOLD & resp_own_valid & resp_own_ready)`.
- Arbitration is combinational and evaluated every cycle:
  - Only one port valid: that port is granted.
  - Both valid: the port opposite the last-accepted pointer `last` is granted.
  - `reqN_ready = can_accept & grant==N`. It depends combinationally on resp_ready of the owning port.
- On accept:
  - The ALU result of the granted port's operands is written to the result register.
  - `own` is set to the granted port and `last` is set to the granted port.
  - State becomes or stays HOLD.
- HOLD with response handshake and no accept: state returns to IDLE.
- HOLD with no handshake: register, `own` and state are held; resp_valid stays asserted.
- `respN_valid = (state==HOLD) & (own==N)`.
- Protocol rules for requesters:
  - src/op must be stable while reqN_valid is high and ready is low.
  - Dropping valid before ready is permitted; nothing is recorded.
- `last` updates only on accept. A non-granted valid port keeps waiting, and no starvation is possible: it wins the next accept.

## Timing
- Reset (async assert, sync use after deassert) sets:
  - state = IDLE, last = 1 (port 0 wins first tie), own = 0, result = 0.
  - All valid/ready outputs = 0.
- Reset asserted mid-HOLD: resp_valid drops immediately (asynchronously) and the held result is discarded.
- Latency: request accepted at edge N, result visible with respN_valid high from cycle N+1.
- Back-to-back operation:
  - If resp_ready is high in the cycle after accept, a new request can be accepted in that same cycle.
  - This gives a sustained rate of 1 op/cycle across both ports.
- Backpressure: an unconsumed result blocks both ports. reqN_ready is 0 while HOLD without a handshake.
- Simultaneous response handshake and new accept for the same port: resp_valid stays high with the new result next cycle, with no bubble.
- Ready for a port that is not the owner has no effect.

## Test plan
- Reset then port0 add 5+7 with resp0_ready=1: req0_ready high in the first cycle; next cycle resp0_valid=1, resp0_result=12, resp1_valid=0.
- Op coverage on port1:
  - sub 3−5 → 0xFFFFFFFE
  - slt 0xFFFFFFFF,1 → 1; sltu same operands → 0
  - sra 0x80000000 by 4 → 0xF8000000
  - op 1111 → 0
- Both ports valid every cycle, resp ready always high: grants alternate 0,1,0,1 starting with port 0; one result per cycle, each correctly tagged.
- Backpressure: hold resp0_ready=0 for 3 cycles after accept:
  - resp0_result stays stable.
  - req0_ready and req1_ready stay 0.
  - When resp0_ready rises, pending port1 is accepted in the same cycle.
- Assert rst_n low during HOLD: resp valid drops without waiting for a clock; after release, port0 wins the first tie.
- Random constrained traffic on both ports with random resp_ready: a scoreboard checks order per port, result values against a reference model, and no lost or duplicated responses.
